// File: rtl/log_lane_if.sv
// Pixel/frame inputs and drawer outputs of one log lane, bundled for the objects mux.
interface log_lane_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        enable;
    logic [3:0]  speed;
    logic        direction;
    logic        logDR;
    logic [7:0]  log_mVGA_RGB;
    logic [4:0]  frame_dx;
    logic [10:0] log0_X;

    // Video timing / control side
    modport master (
        output startOfFrame, pixelX, pixelY, enable, speed, direction,
        input  logDR, log_mVGA_RGB, frame_dx, log0_X
    );

    // Log lane drawer side
    modport slave (
        input  startOfFrame, pixelX, pixelY, enable, speed, direction,
        output logDR, log_mVGA_RGB, frame_dx, log0_X
    );
endinterface

// File: rtl/log_lane.sv
// One horizontal river lane of wrapping logs; position steps once per frame,
// pixel draw request and colour are registered (1-cycle latency).
module log_lane #(
    parameter int unsigned LANE_Y_TOP   = 240,
    parameter int unsigned LANE_HEIGHT  = 32,
    parameter int unsigned LOG_WIDTH    = 96,
    parameter int unsigned NUM_LOGS     = 3,
    parameter int unsigned LOG_SPACING  = 213,
    parameter int unsigned SCREEN_WIDTH = 640,
    parameter int unsigned INIT_X       = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    log_lane_if.slave  bus
);
    localparam int unsigned XW = 11;
    localparam int unsigned AW = 12;
    localparam logic [AW-1:0] SW_A    = AW'(SCREEN_WIDTH);
    localparam logic [7:0]    RGB_EDGE = 8'h60;
    localparam logic [7:0]    RGB_BODY = 8'hA4;

    logic [XW-1:0] posX_q, posX_d;
    logic [4:0]    frame_dx_q, frame_dx_d;
    logic          logDR_q, logDR_d;
    logic [7:0]    rgb_q, rgb_d;

    logic [AW-1:0] sum_c;
    logic [AW-1:0] px_c;
    logic [AW-1:0] start_c [NUM_LOGS];
    logic [AW-1:0] off_c   [NUM_LOGS];
    logic          hit_c;
    logic [AW-1:0] sel_off_c;
    logic          in_lane_c;
    logic [XW-1:0] row_c;
    logic          edge_c;

    // Frame-rate position update; a single conditional wrap is enough since speed < screen width
    always_comb begin
        posX_d     = posX_q;
        frame_dx_d = frame_dx_q;
        sum_c      = {1'b0, posX_q} + AW'(bus.speed);
        if (bus.startOfFrame) begin
            if (!bus.enable) begin
                frame_dx_d = 5'd0;
            end else if (!bus.direction) begin
                posX_d     = (sum_c >= SW_A) ? XW'(sum_c - SW_A) : XW'(sum_c);
                frame_dx_d = {1'b0, bus.speed};
            end else begin
                posX_d     = (posX_q < XW'(bus.speed))
                           ? XW'({1'b0, posX_q} + SW_A - AW'(bus.speed))
                           : posX_q - XW'(bus.speed);
                frame_dx_d = 5'd0 - {1'b0, bus.speed};
            end
        end
    end

    // Per-log start column and wrapped pixel offset from that start
    always_comb begin
        px_c = {1'b0, bus.pixelX};
        for (int i = 0; i < NUM_LOGS; i++) begin
            start_c[i] = ({1'b0, posX_q} + AW'(i * LOG_SPACING) >= SW_A)
                       ? {1'b0, posX_q} + AW'(i * LOG_SPACING) - SW_A
                       : {1'b0, posX_q} + AW'(i * LOG_SPACING);
            off_c[i]   = (px_c >= start_c[i]) ? px_c - start_c[i]
                                              : px_c + SW_A - start_c[i];
        end
    end

    // Hit test with lowest-index priority, then edge/body shading
    always_comb begin
        hit_c     = 1'b0;
        sel_off_c = '0;
        for (int i = 0; i < NUM_LOGS; i++) begin
            if (!hit_c && (off_c[i] < AW'(LOG_WIDTH))) begin
                hit_c     = 1'b1;
                sel_off_c = off_c[i];
            end
        end
        in_lane_c = (bus.pixelX < XW'(SCREEN_WIDTH))
                 && (bus.pixelY >= XW'(LANE_Y_TOP))
                 && (bus.pixelY <  XW'(LANE_Y_TOP + LANE_HEIGHT));
        row_c     = bus.pixelY - XW'(LANE_Y_TOP);
        edge_c    = (sel_off_c < AW'(4))
                 || (sel_off_c >= AW'(LOG_WIDTH - 4))
                 || (row_c < XW'(2))
                 || (row_c >= XW'(LANE_HEIGHT - 2));
        logDR_d   = hit_c && in_lane_c;
        rgb_d     = !logDR_d ? 8'h00 : (edge_c ? RGB_EDGE : RGB_BODY);
    end

    // State and registered pixel outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            posX_q     <= XW'(INIT_X);
            frame_dx_q <= 5'd0;
            logDR_q    <= 1'b0;
            rgb_q      <= 8'h00;
        end else begin
            posX_q     <= posX_d;
            frame_dx_q <= frame_dx_d;
            logDR_q    <= logDR_d;
            rgb_q      <= rgb_d;
        end
    end

    assign bus.log0_X       = posX_q;
    assign bus.frame_dx     = frame_dx_q;
    assign bus.logDR        = logDR_q;
    assign bus.log_mVGA_RGB = rgb_q;

endmodule

// File: tb/tb_log_lane.sv
// Directed + randomized bench for log_lane against an arithmetic lane model.
module tb_log_lane;
    logic clk = 1'b0;
    logic rst = 1'b1;

    log_lane_if bus();

    log_lane dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int m_pos = 0;
    int m_dx  = 0;

    // Reference: which log (lowest index) covers the pixel, and its shade
    function automatic void ref_pix(input int pos, input int x, input int y,
                                    output int dr, output int rgb);
        dr  = 0;
        rgb = 0;
        if (x >= 640 || y < 240 || y >= 272) return;
        for (int i = 0; i < 3; i++) begin
            int s;
            int off;
            s   = (pos + i * 213) % 640;
            off = ((x - s) % 640 + 640) % 640;
            if (off < 96) begin
                dr  = 1;
                rgb = (off < 4 || off >= 92 || (y - 240) < 2 || (y - 240) >= 30) ? 'h60 : 'hA4;
                return;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one pixel cycle, advance the model, check all outputs after the edge
    task automatic step(input int x, input int y, input bit sof, input bit en,
                        input int spd, input bit dir);
        int e_dr;
        int e_rgb;
        @(negedge clk);
        bus.pixelX       = 11'(x);
        bus.pixelY       = 11'(y);
        bus.startOfFrame = sof;
        bus.enable       = en;
        bus.speed        = 4'(spd);
        bus.direction    = dir;
        ref_pix(m_pos, x, y, e_dr, e_rgb);
        if (sof) begin
            if (!en) m_dx = 0;
            else if (!dir) begin
                m_pos = (m_pos + spd) % 640;
                m_dx  = spd;
            end else begin
                m_pos = (m_pos - spd + 640) % 640;
                m_dx  = (32 - spd) % 32;
            end
        end
        @(posedge clk);
        #1;
        check("logDR",    32'(bus.logDR),        32'(e_dr));
        check("rgb",      32'(bus.log_mVGA_RGB), 32'(e_rgb));
        check("frame_dx", 32'(bus.frame_dx),     32'(m_dx));
        check("log0_X",   32'(bus.log0_X),       32'(m_pos));
    endtask

    task automatic rand_step();
        int x, y, spd;
        bit sof, en, dir;
        x   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 2047)) : int'($urandom_range(0, 639));
        y   = int'($urandom_range(230, 280));
        sof = ($urandom_range(0, 5) == 0);
        en  = ($urandom_range(0, 3) != 0);
        spd = int'($urandom_range(0, 15));
        dir = 1'($urandom_range(0, 1));
        step(x, y, sof, en, spd, dir);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_pos = 0;
        m_dx  = 0;
        check("rst_logDR", 32'(bus.logDR),        32'(0));
        check("rst_rgb",   32'(bus.log_mVGA_RGB), 32'(0));
        check("rst_dx",    32'(bus.frame_dx),     32'(0));
        check("rst_x",     32'(bus.log0_X),       32'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        bus.enable       = 1'b0;
        bus.speed        = '0;
        bus.direction    = 1'b0;
        #1;
        check("init_logDR", 32'(bus.logDR),        32'(0));
        check("init_rgb",   32'(bus.log_mVGA_RGB), 32'(0));
        check("init_x",     32'(bus.log0_X),       32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Static lane: body pixel of log 0
        step(10, 250, 1'b0, 1'b0, 0, 1'b0);
        check("static_dr",  32'(bus.logDR),        32'(1));
        check("static_rgb", 32'(bus.log_mVGA_RGB), 32'(8'hA4));

        // Random warm-up then asynchronous reset mid-frame
        repeat (40) rand_step();
        mid_reset();

        // Rightward wrap: walk to 630, then +15 -> 5
        repeat (42) step(int'($urandom_range(0, 639)), 250, 1'b1, 1'b1, 15, 1'b0);
        check("pos630", 32'(bus.log0_X), 32'(630));
        step(300, 250, 1'b1, 1'b1, 15, 1'b0);
        check("wrap_r_x",  32'(bus.log0_X),   32'(5));
        check("wrap_r_dx", 32'(bus.frame_dx), 32'(5'b01111));
        step(2, 250, 1'b0, 1'b1, 0, 1'b0);
        step(8, 250, 1'b0, 1'b1, 0, 1'b0);
        check("r_off3_rgb", 32'(bus.log_mVGA_RGB), 32'(8'h60));
        step(17, 250, 1'b0, 1'b1, 0, 1'b0);
        check("r_off12_rgb", 32'(bus.log_mVGA_RGB), 32'(8'hA4));

        // Leftward wrap through zero: 5 -> 3 -> 638
        step(100, 250, 1'b1, 1'b1, 2, 1'b1);
        step(100, 250, 1'b1, 1'b1, 5, 1'b1);
        check("wrap_l_x",  32'(bus.log0_X),   32'(638));
        check("wrap_l_dx", 32'(bus.frame_dx), 32'(5'b11011));
        step(90, 250, 1'b0, 1'b1, 0, 1'b0);
        check("l_off92_dr",  32'(bus.logDR),        32'(1));
        check("l_off92_rgb", 32'(bus.log_mVGA_RGB), 32'(8'h60));
        step(94, 250, 1'b0, 1'b1, 0, 1'b0);
        check("l_off96_dr", 32'(bus.logDR), 32'(0));

        // Freeze across three frames with changing speed
        for (int k = 0; k < 3; k++) begin
            step(50, 250, 1'b1, 1'b0, 3 + 4 * k, k[0]);
            check("frz_x",  32'(bus.log0_X),   32'(638));
            check("frz_dx", 32'(bus.frame_dx), 32'(0));
        end

        // Lane bounds and blanking over log 0 (covers 638..93)
        step(50, 239, 1'b0, 1'b0, 0, 1'b0);
        check("y239", 32'(bus.logDR), 32'(0));
        step(50, 272, 1'b0, 1'b0, 0, 1'b0);
        check("y272", 32'(bus.logDR), 32'(0));
        step(50, 240, 1'b0, 1'b0, 0, 1'b0);
        check("y240_rgb", 32'(bus.log_mVGA_RGB), 32'(8'h60));
        step(700, 250, 1'b0, 1'b0, 0, 1'b0);
        check("x700", 32'(bus.logDR), 32'(0));

        // Multi-log at posX = 0; start-of-frame cycle still uses old position
        step(639, 256, 1'b1, 1'b1, 2, 1'b0);
        check("race_old_pos", 32'(bus.logDR), 32'(1));
        check("multi_x0", 32'(bus.log0_X), 32'(0));
        step(213, 256, 1'b0, 1'b1, 0, 1'b0);
        check("m213", 32'(bus.logDR), 32'(1));
        step(300, 256, 1'b0, 1'b1, 0, 1'b0);
        check("m300", 32'(bus.logDR), 32'(1));
        step(426, 256, 1'b0, 1'b1, 0, 1'b0);
        check("m426", 32'(bus.logDR), 32'(1));
        step(522, 256, 1'b0, 1'b1, 0, 1'b0);
        check("m522", 32'(bus.logDR), 32'(0));

        // Randomized soak
        repeat (600) rand_step();
        mid_reset();
        repeat (200) rand_step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
